trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: XLEN, 32, datapath width (32 or 64).
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-low; sampled only on posedge clock.
REQ-004 exc_valid  in  1  synchronous exception from execute stage this cycle.
REQ-005 exc_code  in  4  exception cause code (0,2,3,4,6,11).
REQ-006 exc_pc  in  XLEN  pc of faulting instruction.
REQ-007 exc_tval  in  XLEN  trap value for the exception.
REQ-008 irq_sw, irq_timer, irq_ext  in  1 each  level-sensitive machine software/timer/external interrupt lines.
REQ-009 mie_bits  in  XLEN  current mie CSR (bits 3, 7, 11 used).
REQ-010 mstatus_mie  in  1  current mstatus.MIE.
REQ-011 mtvec  in  XLEN  current mtvec CSR.
REQ-012 mepc  in  XLEN  current mepc CSR.
REQ-013 retire_valid  in  1  an instruction retires this cycle; next_pc valid.
REQ-014 next_pc  in  XLEN  pc of the next instruction after the retiring one.
REQ-015 mret_valid  in  1  mret retires this cycle.
REQ-016 stall  out  1  freeze fetch/decode/execute.
REQ-017 flush  out  1  kill all in-flight instructions.
REQ-018 trap_we  out  1  one-cycle strobe: CSR file loads trap_epc/trap_cause/trap_tval, MPIE<=MIE, MIE<=0.
REQ-019 mret_we  out  1  one-cycle strobe: CSR file does MIE<=MPIE.
REQ-020 trap_epc, trap_cause, trap_tval  out  XLEN each  captured trap record.
REQ-021 redirect_valid  out  1  redirect_pc valid.
REQ-022 redirect_pc  out  XLEN  new fetch pc.
REQ-023 redirect_ready  in  1  fetch accepts redirect.
REQ-024 trap_count  out  XLEN  number of traps taken since reset.

Function
REQ-025 FSM states: IDLE, FLUSH, COMMIT, MRET, REDIRECT; only IDLE samples exc_valid, irq lines, mret_valid.
REQ-026 IDLE priority (highest first): exc_valid, enabled interrupt, mret_valid.
REQ-027 Exception in IDLE: capture epc=exc_pc, cause=zero-extended exc_code (bit XLEN-1 = 0), tval=exc_tval; -> FLUSH.
REQ-028 Interrupt taken in IDLE iff mstatus_mie && retire_valid && any(irq_x && mie_bits[x]); code priority ext(11) > sw(3) > timer(7); capture epc=next_pc, cause={1,code}, tval=0; -> FLUSH.
REQ-029 mret_valid in IDLE with no exception/interrupt taken: -> FLUSH, then MRET instead of COMMIT.
REQ-030 FLUSH: flush=1, stall=1 for exactly one cycle; -> COMMIT (trap) or MRET (mret).
REQ-031 COMMIT: trap_we=1 for exactly one cycle; trap_count increments by 1 (wraps modulo 2^XLEN); -> REDIRECT.
REQ-032 MRET: mret_we=1 for exactly one cycle; -> REDIRECT.
REQ-033 REDIRECT: redirect_valid=1, stall=1; redirect_pc held stable until redirect_valid && redirect_ready, then -> IDLE next cycle.
REQ-034 Trap redirect_pc: base={mtvec[XLEN-1:2],2'b00}; if mtvec[1:0]==01 and cause bit XLEN-1 set, base + (cause[XLEN-2:0]<<2); else base.
REQ-035 Mret redirect_pc = mepc sampled on entry to REDIRECT, held while waiting.
REQ-036 stall=1 in every state except IDLE; flush=0 outside FLUSH.
REQ-037 trap_epc/trap_cause/trap_tval change only on IDLE capture; stable through COMMIT and REDIRECT.
REQ-038 Inputs other than redirect_ready ignored outside IDLE; interrupts held by sources are re-evaluated on return to IDLE.
REQ-039 Trap latency: exception in IDLE cycle N -> flush N+1, trap_we N+2, redirect_valid from N+3.

Reset
REQ-040 reset low at posedge: state=IDLE, stall=flush=trap_we=mret_we=redirect_valid=0, trap_epc=trap_cause=trap_tval=redirect_pc=0, trap_count=0.
REQ-041 Reset wins over any state, including mid-REDIRECT with pending handshake; no strobe emitted in the reset cycle.

Verification
REQ-042 exc_valid=1, exc_code=2, exc_pc=0x100, mtvec=0x200 -> flush 1 cycle, trap_we with cause=2, epc=0x100, redirect_pc=0x200, trap_count=1.
REQ-043 irq_timer=1, mie_bits[7]=1, mstatus_mie=1, retire_valid=1, next_pc=0x44, mtvec=0x301 -> cause=0x80000007, epc=0x44, tval=0, redirect_pc=0x31C.
REQ-044 irq_ext and irq_sw and exc_valid (code 11) same cycle -> exception taken, cause=11; interrupts taken after return to IDLE with cause=0x8000000B.
REQ-045 mret_valid=1, mepc=0x88 -> flush, mret_we 1 cycle, redirect_pc=0x88, trap_we never asserted, trap_count unchanged.
REQ-046 redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable 5 cycles, IDLE 1 cycle after ready; reset asserted mid-wait -> all outputs zero next cycle.
REQ-047 irq_sw=1 with mstatus_mie=0 or mie_bits[3]=0 -> no trap, stall stays 0.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and mret from the
// execute stage, flushes the pipe, strobes the CSR file and redirects fetch.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic            irq_ext,
    input  logic [XLEN-1:0] mie_bits,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] next_pc,
    input  logic            mret_valid,
    output logic            stall,
    output logic            flush,
    output logic            trap_we,
    output logic            mret_we,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_tval,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] trap_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_COMMIT,
        S_MRET,
        S_REDIRECT
    } state_t;

    localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic            is_mret_q, is_mret_d;
    logic            stall_q, stall_d;
    logic            flush_q, flush_d;
    logic            trap_we_q, trap_we_d;
    logic            mret_we_q, mret_we_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic [XLEN-1:0] trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_tval_q, trap_tval_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] trap_count_q, trap_count_d;

    // Interrupt qualification and fixed priority: external > software > timer.
    logic            irq_ext_en, irq_sw_en, irq_timer_en;
    logic            irq_take;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] exc_cause;

    assign irq_ext_en   = irq_ext   & mie_bits[11];
    assign irq_sw_en    = irq_sw    & mie_bits[3];
    assign irq_timer_en = irq_timer & mie_bits[7];
    assign irq_take     = mstatus_mie & retire_valid & (irq_ext_en | irq_sw_en | irq_timer_en);

    always_comb begin
        irq_code = 4'd7;
        if (irq_ext_en) begin
            irq_code = 4'd11;
        end else if (irq_sw_en) begin
            irq_code = 4'd3;
        end
    end

    assign irq_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
    assign exc_cause = {{(XLEN-4){1'b0}}, exc_code};

    // Trap target: vectored mode only offsets interrupts, exceptions use the base.
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] vec_offset;
    logic [XLEN-1:0] trap_target;

    assign trap_base   = {mtvec[XLEN-1:2], 2'b00};
    assign vec_offset  = {trap_cause_q[XLEN-3:0], 2'b00};
    assign trap_target = (mtvec[1:0] == 2'b01 && trap_cause_q[XLEN-1])
                         ? trap_base + vec_offset : trap_base;

    logic unused_ok;
    assign unused_ok = ^{mie_bits[XLEN-1:12], mie_bits[10:8], mie_bits[6:4],
                         mie_bits[2:0], trap_cause_q[XLEN-2]};

    always_comb begin
        // NOTE: every _d starts from its _q (strobes from 0) so no path infers a latch.
        state_d          = state_q;
        is_mret_d        = is_mret_q;
        stall_d          = stall_q;
        flush_d          = 1'b0;
        trap_we_d        = 1'b0;
        mret_we_d        = 1'b0;
        trap_epc_d       = trap_epc_q;
        trap_cause_d     = trap_cause_q;
        trap_tval_d      = trap_tval_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        trap_count_d     = trap_count_q;

        unique case (state_q)
            S_IDLE: begin
                stall_d          = 1'b0;
                redirect_valid_d = 1'b0;
                if (exc_valid) begin
                    state_d      = S_FLUSH;
                    is_mret_d    = 1'b0;
                    stall_d      = 1'b1;
                    flush_d      = 1'b1;
                    trap_epc_d   = exc_pc;
                    trap_cause_d = exc_cause;
                    trap_tval_d  = exc_tval;
                end else if (irq_take) begin
                    state_d      = S_FLUSH;
                    is_mret_d    = 1'b0;
                    stall_d      = 1'b1;
                    flush_d      = 1'b1;
                    trap_epc_d   = next_pc;
                    trap_cause_d = irq_cause;
                    trap_tval_d  = '0;
                end else if (mret_valid) begin
                    state_d   = S_FLUSH;
                    is_mret_d = 1'b1;
                    stall_d   = 1'b1;
                    flush_d   = 1'b1;
                end
            end
            S_FLUSH: begin
                stall_d = 1'b1;
                if (is_mret_q) begin
                    state_d   = S_MRET;
                    mret_we_d = 1'b1;
                end else begin
                    state_d      = S_COMMIT;
                    trap_we_d    = 1'b1;
                    trap_count_d = trap_count_q + CNT_ONE;
                end
            end
            S_COMMIT: begin
                state_d          = S_REDIRECT;
                stall_d          = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = trap_target;
            end
            S_MRET: begin
                state_d          = S_REDIRECT;
                stall_d          = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mepc;
            end
            S_REDIRECT: begin
                // Hold target and valid until fetch takes the handshake.
                stall_d = 1'b1;
                if (redirect_valid_q && redirect_ready) begin
                    state_d          = S_IDLE;
                    stall_d          = 1'b0;
                    redirect_valid_d = 1'b0;
                end
            end
            default: begin
                state_d          = S_IDLE;
                stall_d          = 1'b0;
                redirect_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            is_mret_q        <= 1'b0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
            trap_we_q        <= 1'b0;
            mret_we_q        <= 1'b0;
            trap_epc_q       <= '0;
            trap_cause_q     <= '0;
            trap_tval_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            trap_count_q     <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q          <= state_d;
            is_mret_q        <= is_mret_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
            trap_we_q        <= trap_we_d;
            mret_we_q        <= mret_we_d;
            trap_epc_q       <= trap_epc_d;
            trap_cause_q     <= trap_cause_d;
            trap_tval_q      <= trap_tval_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            trap_count_q     <= trap_count_d;
        end
    end

    assign stall          = stall_q;
    assign flush          = flush_q;
    assign trap_we        = trap_we_q;
    assign mret_we        = mret_we_q;
    assign trap_epc       = trap_epc_q;
    assign trap_cause     = trap_cause_q;
    assign trap_tval      = trap_tval_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign trap_count     = trap_count_q;

    a_flush_stalls : assert property (@(posedge clock) disable iff (!reset)
        flush_q |-> stall_q);
    a_one_strobe : assert property (@(posedge clock) disable iff (!reset)
        !(trap_we_q && mret_we_q));

endmodule
